// File: rtl/ethernetsystem_descriptor_fetch_pkg.sv
// ethernetsystem_desc_pkg: shared definitions for the descriptor fetch engine.
//   state_t        - FSM state encoding
//   W_*            - word offsets inside a 4-word descriptor
//   OWNED_HW/EOP/END_CHAIN - control word flag bit positions
//   STATUS_LSB     - LSB of the 8-bit status field in the control word
//   wb_word()      - builds the control word written back on completion
package ethernetsystem_desc_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, CHECK, PRESENT, EXEC, WRITEBACK, NEXT
  } state_t;

  localparam logic [1:0] W_SRC  = 2'd0;
  localparam logic [1:0] W_DST  = 2'd1;
  localparam logic [1:0] W_NEXT = 2'd2;
  localparam logic [1:0] W_CTRL = 2'd3;

  localparam int OWNED_HW   = 31;
  localparam int EOP        = 30;
  localparam int END_CHAIN  = 29;
  localparam int STATUS_LSB = 16;

  // Hand ownership back to software, keep the flag/reserved bits as read,
  // status = {6'b0, error, complete}, length field = bytes actually moved.
  function automatic logic [31:0] wb_word(input logic [31:0] ctrl,
                                          input logic        err,
                                          input logic [15:0] bytes);
    logic [31:0] w;
    w                  = ctrl;
    w[OWNED_HW]        = 1'b0;
    w[STATUS_LSB +: 8] = {6'b0, err, 1'b1};
    w[15:0]            = bytes;
    return w;
  endfunction

endpackage

// File: rtl/ethernetsystem_descriptor_fetch.sv
// ethernetsystem_descriptor_fetch: Avalon-MM master that walks a linked chain
// of 4-word DMA descriptors, hands each hardware-owned descriptor to the DMA
// engine, waits for completion and writes status back into the descriptor.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, head_ptr       - kick off a walk at a 4-aligned word address
//   busy, chain_done, chain_error - walk status / termination pulses
//   mem_*                 - Avalon-MM master to the descriptor memory
//   desc_valid/ready, desc_src/dst/len/eop - descriptor stream to the DMA
//   done_valid, done_bytes, done_error     - completion from the DMA
//   stat_desc_count       - completed-descriptor counter
//
// Optional feature: define DESC_FETCH_STATS_EN to build the saturating
// completed-descriptor counter; otherwise stat_desc_count is tied to 0.
module ethernetsystem_descriptor_fetch
  import ethernetsystem_desc_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  output logic              busy,
  output logic              chain_done,
  output logic              chain_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [LEN_W-1:0]  desc_len,
  output logic              desc_eop,
  input  logic              done_valid,
  input  logic [LEN_W-1:0]  done_bytes,
  input  logic              done_error,
  output logic [15:0]       stat_desc_count
);

  state_t            state;
  logic [ADDR_W-1:0] cur_ptr;
  logic [1:0]        k;        // read issue index within the descriptor
  logic [2:0]        rd_cnt;   // words captured so far (0..4)
  logic [3:0][31:0]  w;        // captured descriptor words
  logic [3:0][31:0]  w_fwd;    // w with this cycle's read data merged in
  logic              dn_err;
  logic              mem_accept;
  logic              rd_take;
  logic              last_word;
  logic              wb_done;
  logic              start_ok;
  logic [ADDR_W-1:0] nxt_ptr;

  assign mem_byteenable = 4'hF;
  assign mem_accept     = mem_chipselect && !mem_waitrequest;
  // Read data is only meaningful while a fetch is in flight; stragglers
  // after a reset land in IDLE and are dropped here.
  assign rd_take   = mem_readdatavalid && (state == FETCH || state == WAIT) && !rd_cnt[2];
  assign last_word = (rd_cnt == 3'd4) || (rd_take && rd_cnt == 3'd3);
  assign wb_done   = (state == WRITEBACK) && mem_accept;
  assign start_ok  = (state == IDLE) && start && (head_ptr[1:0] == 2'b00);
  assign nxt_ptr   = w[W_NEXT][ADDR_W-1:0];

  always_comb begin
    w_fwd = w;
    if (rd_take) w_fwd[rd_cnt[1:0]] = mem_readdata;
  end

  assign desc_src = w[W_SRC];
  assign desc_dst = w[W_DST];
  assign desc_len = w[W_CTRL][LEN_W-1:0];
  assign desc_eop = w[W_CTRL][EOP];

  // Termination decisions are taken on the edge that enters CHECK / NEXT so
  // the done/error pulse (and busy falling) coincide with those states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cur_ptr        <= '0;
      k              <= '0;
      rd_cnt         <= '0;
      w              <= '0;
      dn_err         <= 1'b0;
      busy           <= 1'b0;
      chain_done     <= 1'b0;
      chain_error    <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      desc_valid     <= 1'b0;
    end else begin
      chain_done  <= 1'b0;
      chain_error <= 1'b0;
      if (rd_take) begin
        w      <= w_fwd;
        rd_cnt <= rd_cnt + 3'd1;
      end
      case (state)
        IDLE: if (start) begin
          if (head_ptr[1:0] != 2'b00) begin
            chain_error <= 1'b1;
          end else begin
            cur_ptr        <= head_ptr;
            busy           <= 1'b1;
            k              <= '0;
            rd_cnt         <= '0;
            mem_address    <= head_ptr;
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b0;
            state          <= FETCH;
          end
        end
        FETCH: if (mem_accept) begin
          if (k == 2'd3) begin
            mem_chipselect <= 1'b0;
            state          <= WAIT;
          end else begin
            k           <= k + 2'd1;
            mem_address <= cur_ptr + ADDR_W'(k) + ADDR_W'(1);
          end
        end
        WAIT: if (last_word) begin
          state <= CHECK;
          if (!w_fwd[W_CTRL][OWNED_HW]) begin
            chain_done <= 1'b1;
            busy       <= 1'b0;
          end else if (!w_fwd[W_CTRL][END_CHAIN] && w_fwd[W_NEXT][1:0] != 2'b00) begin
            chain_error <= 1'b1;
            busy        <= 1'b0;
          end
        end
        CHECK: begin
          if (busy) begin
            desc_valid <= 1'b1;
            state      <= PRESENT;
          end else begin
            state <= IDLE;
          end
        end
        PRESENT: if (desc_ready) begin
          desc_valid <= 1'b0;
          state      <= EXEC;
        end
        EXEC: if (done_valid) begin
          dn_err         <= done_error;
          mem_writedata  <= wb_word(w[W_CTRL], done_error, 16'(done_bytes));
          mem_address    <= cur_ptr + ADDR_W'(W_CTRL);
          mem_chipselect <= 1'b1;
          mem_write      <= 1'b1;
          state          <= WRITEBACK;
        end
        WRITEBACK: if (mem_accept) begin
          mem_chipselect <= 1'b0;
          mem_write      <= 1'b0;
          state          <= NEXT;
          if (dn_err) begin
            chain_error <= 1'b1;
            busy        <= 1'b0;
          end else if (w[W_CTRL][END_CHAIN]) begin
            chain_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        NEXT: begin
          if (busy) begin
            cur_ptr        <= nxt_ptr;
            k              <= '0;
            rd_cnt         <= '0;
            mem_address    <= nxt_ptr;
            mem_chipselect <= 1'b1;
            state          <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DESC_FETCH_STATS_EN
  logic [15:0] stat_q;
  always_ff @(posedge clk) begin
    if (reset || start_ok)            stat_q <= '0;
    else if (wb_done && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end
  assign stat_desc_count = stat_q;
`else
  logic unused_stat;
  assign unused_stat     = start_ok ^ wb_done;
  assign stat_desc_count = '0;
`endif

endmodule

// File: tb/tb_ethernetsystem_descriptor_fetch.sv
// Self-checking bench: random memory images and downstream timing, checked
// against a chain-walking reference model that operates on a copy of memory.
module tb_ethernetsystem_descriptor_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] head_ptr;
  logic        busy, chain_done, chain_error;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_src, desc_dst;
  logic [15:0] desc_len;
  logic        desc_eop;
  logic        done_valid;
  logic [15:0] done_bytes;
  logic        done_error;
  logic [15:0] stat_desc_count;

  ethernetsystem_descriptor_fetch #(.ADDR_W(11), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .head_ptr(head_ptr),
    .busy(busy), .chain_done(chain_done), .chain_error(chain_error),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .desc_eop(desc_eop), .done_valid(done_valid), .done_bytes(done_bytes),
    .done_error(done_error), .stat_desc_count(stat_desc_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave model ----------------
  logic [31:0] mem     [2048];
  logic [31:0] ref_mem [2048];
  int          cyc = 0;
  bit          stress = 0;
  int          max_lat = 1;
  int          rq_due[$];
  logic [31:0] rq_dat[$];
  int          last_due = -1;
  int          rd_count = 0, wr_count = 0;
  bit          stall_prev = 0;
  logic [45:0] prev_bus;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int due;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = rq_dat.pop_front();
      void'(rq_due.pop_front());
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = $urandom;
    end
    if (stall_prev && !reset)
      chk("stall_hold", {mem_chipselect, mem_write, mem_address, mem_writedata}, prev_bus);
    mem_waitrequest = stress ? 1'($urandom % 2) : 1'b0;
    if (mem_chipselect && !mem_waitrequest && !reset) begin
      if (mem_write) begin
        mem[mem_address] = mem_writedata;
        wr_count++;
      end else begin
        rd_count++;
        due = cyc + $urandom_range(1, max_lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq_due.push_back(due);
        rq_dat.push_back(mem[mem_address]);
      end
    end
    stall_prev = mem_chipselect && mem_waitrequest && !reset;
    prev_bus   = {mem_chipselect, mem_write, mem_address, mem_writedata};
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_src[$], exp_dst[$], exp_ctl[$];
  int          exp_kind, exp_reads, exp_wb;
  logic [15:0] pb[64];
  int          stat_exp = 0;
  int          first_dv, t_end;

  // Walk the chain on ref_mem, applying the writebacks the DMA would cause.
  task automatic model_walk(input logic [10:0] head, input int err_at);
    logic [10:0] p;
    logic [31:0] c;
    logic [10:0] n;
    exp_src.delete(); exp_dst.delete(); exp_ctl.delete();
    exp_reads = 0; exp_wb = 0; exp_kind = 0;
    if (head[1:0] != 2'b00) begin exp_kind = 2; return; end
    p = head;
    for (int i = 0; i < 64; i++) begin
      exp_reads += 4;
      c = ref_mem[p + 11'd3];
      n = ref_mem[p + 11'd2][10:0];
      if (!c[31]) begin exp_kind = 1; return; end
      if (!c[29] && n[1:0] != 2'b00) begin exp_kind = 2; return; end
      exp_src.push_back(ref_mem[p]);
      exp_dst.push_back(ref_mem[p + 11'd1]);
      exp_ctl.push_back(c);
      ref_mem[p + 11'd3] = {1'b0, c[30:24], 6'b0, (i == err_at), 1'b1, pb[i]};
      exp_wb++;
      if (i == err_at) begin exp_kind = 2; return; end
      if (c[29])       begin exp_kind = 1; return; end
      p = n;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
  endtask

  task automatic put_desc(input logic [10:0] b, input logic [10:0] nxt, input logic [31:0] ctl);
    logic [31:0] r;
    r = $urandom;
    mem[b]         = $urandom;
    mem[b + 11'd1] = $urandom;
    mem[b + 11'd2] = {r[31:11], nxt};
    mem[b + 11'd3] = ctl;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, chain_done, chain_error, mem_chipselect, mem_write, desc_valid}, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_wdata"}, mem_writedata, 0);
    chk({tag, "_desc"}, {desc_src, desc_dst}, 0);
    chk({tag, "_len"}, {desc_len, desc_eop}, 0);
    chk({tag, "_stat"}, stat_desc_count, 0);
  endtask

  // One walk: model, start pulse, downstream behaviour, final checks.
  task automatic run_chain(input logic [10:0] head, input int err_at,
                           input bit abort, input int force_b0);
    int hs = 0, phase = 0, dly = 0, nd = 0, ne = 0, post = 0, rd0, wr0, diff;
    bit ended = 0;
    for (int i = 0; i < 64; i++) pb[i] = 16'($urandom);
    if (force_b0 >= 0) pb[0] = 16'(force_b0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
    model_walk(head, err_at);
    rd0 = rd_count; wr0 = wr_count;
    first_dv = -1; t_end = -1;
    @(negedge clk);
    start = 1'b1; head_ptr = head;
    for (int rel = 1; rel < 4000 && post < 3; rel++) begin
      @(negedge clk);
      start = 1'b0; desc_ready = 1'b0; done_valid = 1'b0;
      done_bytes = 16'($urandom); done_error = 1'($urandom);
      if (ended) post++;
      if (rel == 1) chk("busy_start", busy, head[1:0] == 2'b00);
      if (desc_valid && first_dv < 0) first_dv = rel;
      if (chain_done) nd++;
      if (chain_error) ne++;
      if ((chain_done || chain_error) && !ended) begin
        ended = 1; t_end = rel;
        chk("busy_at_end", busy, 0);
      end
      if (phase == 0 && desc_valid) begin
        if (hs < exp_src.size()) begin
          chk("desc_src", desc_src, exp_src[hs]);
          chk("desc_dst", desc_dst, exp_dst[hs]);
          chk("desc_len", desc_len, exp_ctl[hs][15:0]);
          chk("desc_eop", desc_eop, exp_ctl[hs][30]);
        end else begin
          chk("extra_desc", hs, exp_src.size());
        end
        desc_ready = stress ? 1'($urandom % 2) : 1'b1;
        if (desc_ready) begin
          // done_valid alongside the handshake must be ignored
          if ($urandom % 2) begin done_valid = 1'b1; done_error = 1'b1; end
          hs++; phase = 1; dly = $urandom_range(1, 3);
        end
      end else if (phase == 1) begin
        if (abort) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk_zero("rst_exec");
          stat_exp = 0;
          return;
        end
        dly--;
        if (dly == 0) begin
          done_valid = 1'b1;
          done_bytes = pb[hs-1];
          done_error = (hs - 1 == err_at);
          phase = 0;
        end
      end
    end
    if (!ended) chk("timeout", 1, 0);
    chk("desc_count", hs, exp_src.size());
    chk("done_pulses", nd, exp_kind == 1);
    chk("error_pulses", ne, exp_kind == 2);
    chk("reads", rd_count - rd0, exp_reads);
    chk("writes", wr_count - wr0, exp_wb);
    diff = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image", diff, 0);
    if (head[1:0] == 2'b00) stat_exp = exp_wb;
`ifdef DESC_FETCH_STATS_EN
    chk("stat", stat_desc_count, stat_exp);
`else
    chk("stat", stat_desc_count, 0);
`endif
  endtask

  initial begin
    logic [10:0] base[4];
    int r;
    reset = 1'b1; start = 1'b0; head_ptr = '0; desc_ready = 1'b0;
    done_valid = 1'b0; done_bytes = '0; done_error = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    chk("byteenable", mem_byteenable, 4'hF);
    reset = 1'b0;

    // single descriptor, zero-wait timing
    fill_mem();
    put_desc(11'h010, 11'h000, 32'hE000_0040);
    run_chain(11'h010, -1, 0, 16'h0040);
    chk("single_wb", mem[11'h013], 32'h6001_0040);
    chk("single_dv_cycle", first_dv, 7);

    // three-descriptor chain
    fill_mem();
    put_desc(11'h000, 11'h100, {3'b100, 13'($urandom), 16'($urandom)});
    put_desc(11'h100, 11'h7FC, {3'b110, 13'($urandom), 16'($urandom)});
    put_desc(11'h7FC, 11'($urandom), {3'b101, 13'($urandom), 16'($urandom)});
    run_chain(11'h000, -1, 0, -1);

    // not owned
    fill_mem();
    put_desc(11'h020, 11'h030, 32'h0000_0000);
    run_chain(11'h020, -1, 0, -1);
    chk("notown_done_cycle", t_end, 6);
    chk("notown_no_dv", first_dv, -1);

    // waitrequest and read-latency stress
    stress = 1; max_lat = 3;
    for (int it = 0; it < 6; it++) begin
      fill_mem();
      r = $urandom % 16;
      for (int k = 0; k < 4; k++) base[k] = 11'(((r + k * 5) % 16) * 128 + ($urandom % 32) * 4);
      for (int k = 0; k < 4; k++)
        put_desc(base[k], (k < 3) ? base[k+1] : 11'($urandom),
                 {1'b1, 1'($urandom), (k == 3), 29'($urandom)});
      run_chain(base[0], (it == 5) ? 2 : -1, 0, -1);
    end
    stress = 0; max_lat = 1;

    // downstream error on the first descriptor
    fill_mem();
    put_desc(11'h040, 11'h080, 32'h8000_0100);
    put_desc(11'h080, 11'h000, 32'hA000_0100);
    run_chain(11'h040, 0, 0, -1);
    chk("err_status", mem[11'h043][23:16], 8'h03);

    // misaligned next pointer
    fill_mem();
    put_desc(11'h0C0, 11'h105, 32'h8000_0010);
    run_chain(11'h0C0, -1, 0, -1);
    chk("misnext_cycle", t_end, 6);

    // misaligned head
    run_chain(11'h0C2, -1, 0, -1);
    chk("mishead_cycle", t_end, 1);

    // self-loop terminates once ownership is returned
    fill_mem();
    put_desc(11'h200, 11'h200, 32'h8000_0020);
    run_chain(11'h200, -1, 0, -1);

    // reset while executing, then restart
    fill_mem();
    put_desc(11'h300, 11'h000, 32'hE000_0080);
    run_chain(11'h300, -1, 1, -1);
    repeat (2) @(negedge clk);
    run_chain(11'h300, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ethernetsystem_descriptor_fetch.md
Name: ethernetsystem_descriptor_fetch

Overview:
- Avalon-MM master that walks a linked chain of 4-word DMA descriptors held in the 2048x32 single-port descriptor memory.
- Presents each descriptor owned by hardware to the downstream DMA engine on a valid/ready stream.
- Waits for completion, then writes status back into the descriptor and follows the next pointer.
- Sits between the descriptor memory (its s2 port) and the Ethernet TX/RX DMA datapath.

Parameters:
- ADDR_W, 11, descriptor memory word-address width.
- LEN_W, 16, byte-length field width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin walking the chain at head_ptr.
- head_ptr  in  ADDR_W  word address of the first descriptor; must be 4-aligned.
- busy  out  1  high from the start acceptance until the chain ends.
- chain_done  out  1  one-cycle pulse at normal chain termination.
- chain_error  out  1  one-cycle pulse at error termination.
- mem_address  out  ADDR_W  descriptor memory word address.
- mem_chipselect  out  1  access request.
- mem_write  out  1  write qualifier.
- mem_byteenable  out  4  always 4'hF.
- mem_writedata  out  32  write data.
- mem_waitrequest  in  1  interconnect stall; hold all mem_* outputs while high.
- mem_readdata  in  32  read data.
- mem_readdatavalid  in  1  read data strobe.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  downstream accepts the descriptor.
- desc_src  out  32  word0 of the descriptor.
- desc_dst  out  32  word1 of the descriptor.
- desc_len  out  LEN_W  word3[15:0].
- desc_eop  out  1  word3[30].
- done_valid  in  1  downstream finished the current descriptor.
- done_bytes  in  LEN_W  actual bytes transferred.
- done_error  in  1  downstream error.
- stat_desc_count  out  16  count of descriptors completed (see Optional Feature).

Behaviour:
- Descriptor format, 4 words at base b:
  - b+0: source address.
  - b+1: destination address.
  - b+2[10:0]: next pointer.
  - b+3: control/length word. Bit31 OWNED_HW, bit30 EOP, bit29 END_CHAIN, bits[23:16] status, bits[15:0] length.
- Reset values: all outputs 0; FSM in IDLE; the read counter and descriptor registers are cleared.
- Reset mid-operation returns the FSM to IDLE in the same edge. Any late mem_readdatavalid is then ignored.
- IDLE:
  - On start, latch head_ptr into cur_ptr, set busy, go to FETCH.
  - If head_ptr[1:0] != 0, pulse chain_error and stay in IDLE with busy=0.
- FETCH:
  - Issue 4 reads, mem_address = cur_ptr + k for k = 0..3.
  - k advances only on cycles where chipselect is high and mem_waitrequest is low.
  - Address arithmetic is modulo 2^ADDR_W. Base is aligned, so no wrap occurs within a descriptor.
  - After the 4th read is accepted, go to WAIT.
- WAIT:
  - Capture mem_readdata into word slot rd_cnt on each mem_readdatavalid.
  - Read data may also arrive during FETCH and must be captured there.
  - After 4 words, go to CHECK.
- CHECK, one cycle:
  - OWNED_HW = 0: pulse chain_done, go to IDLE.
  - Next pointer not 4-aligned while END_CHAIN = 0: pulse chain_error, go to IDLE.
  - Otherwise go to PRESENT.
- PRESENT:
  - desc_valid = 1. desc_* fields stay stable until the handshake.
  - On desc_valid & desc_ready, drop desc_valid the next cycle and go to EXEC.
- EXEC:
  - Wait for done_valid. done_valid is ignored in every other state.
  - Latch done_bytes and done_error, go to WRITEBACK.
- WRITEBACK:
  - Single write to cur_ptr+3, held until mem_waitrequest is low.
  - Written word:
    - bit31 = 0.
    - bits[30:29] as read.
    - bits[28:24] as read.
    - status[23:16] = {6'b0, done_error, 1'b1}.
    - [15:0] = done_bytes.
- NEXT, one cycle:
  - done_error = 1: pulse chain_error, go to IDLE.
  - END_CHAIN = 1: pulse chain_done, go to IDLE.
  - Otherwise cur_ptr = word2[10:0], go to FETCH.
- busy falls in the same cycle as the chain_done or chain_error pulse. start is ignored while busy.
- Timing with zero waitrequest and 1-cycle read latency, start at cycle 0:
  - Reads at cycles 1-4, data at cycles 2-5.
  - CHECK at cycle 6, desc_valid from cycle 7.
- done_valid and desc_ready may both be high in the same cycle. Only the signal relevant to the current state has effect.
- A self-loop next pointer (next = cur_ptr) is legal. It terminates only when OWNED_HW reads 0.

Optional Feature:
- Macro DESC_FETCH_STATS_EN.
- Defined:
  - stat_desc_count increments, saturating at 16'hFFFF, on every completed writeback.
  - It clears on reset and on an accepted start.
- Undefined: stat_desc_count is tied to 0 and no counter logic exists.

Decomposition:
- Package ethernetsystem_desc_pkg holds:
  - state enum (IDLE, FETCH, WAIT, CHECK, PRESENT, EXEC, WRITEBACK, NEXT);
  - word offsets (W_SRC=0, W_DST=1, W_NEXT=2, W_CTRL=3);
  - bit positions (OWNED_HW=31, EOP=30, END_CHAIN=29);
  - status field LSB = 16.
- No sub-module. A single FSM with a 4-word capture register file is the natural structure.

Test Plan:
- Single descriptor:
  - Stimulus: head=0x010; word3=0xE000_0040; done_bytes=0x40.
  - Response: desc_len=0x40 and desc_eop=1; memory[0x013]=0x6001_0040; chain_done pulses once; busy low afterwards.
- Three-descriptor chain:
  - Stimulus: 0x000 → 0x100 → 0x7FC, END_CHAIN on the last.
  - Response: 3 desc handshakes in order; 3 writebacks; stat_desc_count=3 with the macro defined, 0 without.
- Not owned:
  - Stimulus: head word3=0x0000_0000.
  - Response: no desc_valid; chain_done at cycle 6 after start; no memory write.
- Waitrequest stress:
  - Stimulus: random mem_waitrequest at 50%, read latency 1-3 cycles.
  - Response: desc fields equal the memory contents; mem_* outputs stable while stalled.
- Error paths:
  - Stimulus (a): done_error=1.
  - Response (a): status=0x03 written back; chain_error pulses; next descriptor never fetched.
  - Stimulus (b): misaligned next pointer 0x105.
  - Response (b): chain_error pulses in CHECK.
- Reset mid-EXEC, then start again:
  - Response: all outputs 0 the cycle after reset; the restarted chain completes correctly.
